fetch_unit: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline, directly upstream of the IF/ID pipeline buffer. It holds the program counter, issues word requests to a variable-latency instruction memory over a req/ready handshake, and applies stall and branch/jump redirects. It presents each fetched instruction with its PC+4 to IF/ID, plus a flush strobe. Bubbles are all-zero, which decodes as NOP.

---
 rtl/fetch_unit_if.sv | 15 +
 rtl/fetch_unit.sv | 152 +++++++++++++++
 tb/tb_fetch_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_unit_if : instruction-memory req/ready handshake bundle     |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        ready;

  modport master (output req, output addr, input rdata, input ready);
  modport slave  (input req, input addr, output rdata, output ready);
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_unit : PC, variable-latency imem fetch, stall and redirect  |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        stall,
  input  wire logic        branch_taken,
  input  wire logic [31:0] branch_target,
  input  wire logic        jump,
  input  wire logic [31:0] jump_target,
  fetch_unit_if.master     imem,
  output logic      [31:0] PC_out,
  output logic      [31:0] instruction_out,
  output logic             valid_out,
  output logic             flush_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic        r_req;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_instr;
  logic [31:0] r_pc_out;
  logic [31:0] r_instr_out;
  logic        r_valid_out;

  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;

  // Branch resolves in an older stage than jump decode, so it wins.
  assign w_redirect = branch_taken | jump;
  assign w_target   = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;
  assign w_pc_plus4 = r_pc + 32'd4;

  assign flush_out       = w_redirect;
  assign imem.req        = r_req;
  assign imem.addr       = r_addr;
  assign PC_out          = r_pc_out;
  assign instruction_out = r_instr_out;
  assign valid_out       = r_valid_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_addr       <= RESET_PC;
      r_req        <= 1'b0;
      r_skid_pc    <= 32'd0;
      r_skid_instr <= 32'd0;
      r_pc_out     <= 32'd0;
      r_instr_out  <= 32'd0;
      r_valid_out  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_req   <= 1'b1;
          r_state <= FETCH;
          if (w_redirect) begin
            r_pc   <= w_target;
            r_addr <= w_target;
          end else begin
            r_addr <= r_pc;
          end
        end

        FETCH: begin
          if (w_redirect) begin
            r_pc        <= w_target;
            r_pc_out    <= 32'd0;
            r_instr_out <= 32'd0;
            r_valid_out <= 1'b0;
            if (imem.ready) begin
              r_addr <= w_target;
            end else begin
              // Request at the old address must complete before reissuing.
              r_state <= DRAIN;
            end
          end else if (imem.ready) begin
            r_pc <= w_pc_plus4;
            if (!stall) begin
              r_addr      <= w_pc_plus4;
              r_pc_out    <= w_pc_plus4;
              r_instr_out <= imem.rdata;
              r_valid_out <= 1'b1;
            end else begin
              r_skid_pc    <= w_pc_plus4;
              r_skid_instr <= imem.rdata;
              r_req        <= 1'b0;
              r_state      <= HOLD;
            end
          end else if (!stall) begin
            r_pc_out    <= 32'd0;
            r_instr_out <= 32'd0;
            r_valid_out <= 1'b0;
          end
        end

        DRAIN: begin
          if (w_redirect) begin
            r_pc <= w_target;
          end
          if (w_redirect || !stall) begin
            r_pc_out    <= 32'd0;
            r_instr_out <= 32'd0;
            r_valid_out <= 1'b0;
          end
          if (imem.ready) begin
            r_addr  <= w_redirect ? w_target : r_pc;
            r_state <= FETCH;
          end
        end

        HOLD: begin
          if (w_redirect) begin
            r_pc        <= w_target;
            r_addr      <= w_target;
            r_req       <= 1'b1;
            r_state     <= FETCH;
            r_pc_out    <= 32'd0;
            r_instr_out <= 32'd0;
            r_valid_out <= 1'b0;
          end else if (!stall) begin
            r_pc_out    <= r_skid_pc;
            r_instr_out <= r_skid_instr;
            r_valid_out <= 1'b1;
            r_addr      <= r_pc;
            r_req       <= 1'b1;
            r_state     <= FETCH;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fetch_unit : directed scoreboard bench for fetch_unit          |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        mem_ready;
  logic [31:0] PC_out, instruction_out;
  logic        valid_out, flush_out;

  logic        zero_1b = 1'b0;
  logic [31:0] zero_32 = 32'd0;
  logic [31:0] w_PC_out, w_instruction_out;
  logic        w_valid_out, w_flush_out;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  fetch_unit_if bus ();
  fetch_unit_if bus_w ();

  assign bus.ready   = mem_ready;
  assign bus.rdata   = bus.addr ^ 32'hA5A5_0000;
  assign bus_w.ready = 1'b1;
  assign bus_w.rdata = bus_w.addr ^ 32'hA5A5_0000;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .imem(bus),
    .PC_out(PC_out), .instruction_out(instruction_out),
    .valid_out(valid_out), .flush_out(flush_out)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset), .stall(zero_1b),
    .branch_taken(zero_1b), .branch_target(zero_32),
    .jump(zero_1b), .jump_target(zero_32), .imem(bus_w),
    .PC_out(w_PC_out), .instruction_out(w_instruction_out),
    .valid_out(w_valid_out), .flush_out(w_flush_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.pc4   = a + 32'd4;
    e.instr = a ^ 32'hA5A5_0000;
    sb.push_back(e);
  endtask

  // Advance one edge; a valid output not frozen by stall must match the scoreboard head.
  task automatic tick();
    logic st, rd;
    exp_t e;
    st = stall;
    rd = branch_taken | jump;
    @(posedge clk);
    #1;
    if (valid_out && !(st && !rd)) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL sb_underflow: observed valid PC_out %h expected no output", PC_out);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pc_out", PC_out, e.pc4);
        check("instr_out", instruction_out, e.instr);
      end
    end
  endtask

  initial begin
    logic [31:0] exp_addr;
    reset = 1'b1; stall = 1'b0; mem_ready = 1'b1;
    branch_taken = 1'b0; branch_target = 32'd0;
    jump = 1'b0; jump_target = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_pc_out", PC_out, 32'd0);
    check("rst_instr", instruction_out, 32'd0);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_req", {31'd0, bus.req}, 32'd0);
    check("rst_addr", bus.addr, 32'd0);
    check("rst_addr_w", bus_w.addr, 32'hFFFF_FFFC);
    reset = 1'b0;

    // Zero-wait streaming
    tick();
    check("first_req", {31'd0, bus.req}, 32'd1);
    check("first_addr", bus.addr, 32'd0);
    check("first_valid", {31'd0, valid_out}, 32'd0);
    push(32'd0); push(32'd4); push(32'd8);
    tick(); tick(); tick();
    check("stream_addr", bus.addr, 32'hC);

    // Ready every third cycle
    exp_addr = 32'hC;
    for (int k = 0; k < 2; k++) begin
      mem_ready = 1'b0;
      tick();
      check("wait_valid", {31'd0, valid_out}, 32'd0);
      check("wait_instr", instruction_out, 32'd0);
      check("wait_addr", bus.addr, exp_addr);
      tick();
      check("wait_valid2", {31'd0, valid_out}, 32'd0);
      check("wait_addr2", bus.addr, exp_addr);
      mem_ready = 1'b1;
      push(exp_addr);
      tick();
      exp_addr = exp_addr + 32'd4;
    end

    // Stall on accept edge for 4 cycles
    stall = 1'b1;
    push(exp_addr);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("hold_req", {31'd0, bus.req}, 32'd0);
      check("hold_pc_out", PC_out, 32'h14);
      check("hold_instr", instruction_out, 32'hA5A5_0010);
    end
    stall = 1'b0;
    tick();
    check("release_req", {31'd0, bus.req}, 32'd1);
    check("release_addr", bus.addr, 32'h18);

    // Jump while request at 0x20 outstanding
    push(32'h18); push(32'h1C);
    tick(); tick();
    check("pre_jump_addr", bus.addr, 32'h20);
    mem_ready = 1'b0;
    tick();
    jump = 1'b1; jump_target = 32'h100;
    #1;
    check("flush_jump", {31'd0, flush_out}, 32'd1);
    tick();
    jump = 1'b0;
    #1;
    check("flush_clear", {31'd0, flush_out}, 32'd0);
    check("drain_addr", bus.addr, 32'h20);
    check("drain_req", {31'd0, bus.req}, 32'd1);
    check("drain_valid", {31'd0, valid_out}, 32'd0);
    tick();
    check("drain_addr2", bus.addr, 32'h20);
    mem_ready = 1'b1;
    tick();
    check("redirect_addr", bus.addr, 32'h100);
    check("discard_valid", {31'd0, valid_out}, 32'd0);
    push(32'h100);
    tick();

    // Branch and jump together while held
    stall = 1'b1;
    tick();
    check("hold2_req", {31'd0, bus.req}, 32'd0);
    branch_taken = 1'b1; branch_target = 32'h200;
    jump = 1'b1; jump_target = 32'h300;
    #1;
    check("flush_both", {31'd0, flush_out}, 32'd1);
    tick();
    branch_taken = 1'b0; jump = 1'b0;
    check("br_wins_addr", bus.addr, 32'h200);
    check("br_req", {31'd0, bus.req}, 32'd1);
    check("br_bubble_valid", {31'd0, valid_out}, 32'd0);
    check("br_bubble_pc", PC_out, 32'd0);
    check("br_bubble_instr", instruction_out, 32'd0);
    stall = 1'b0;
    push(32'h200);
    tick();
    push(32'h204);
    tick();

    // Asynchronous reset mid-fetch
    mem_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async_valid", {31'd0, valid_out}, 32'd0);
    check("async_pc_out", PC_out, 32'd0);
    check("async_instr", instruction_out, 32'd0);
    check("async_req", {31'd0, bus.req}, 32'd0);
    check("async_addr", bus.addr, 32'd0);
    tick();
    reset = 1'b0;
    mem_ready = 1'b1;
    tick();
    check("refetch_addr", bus.addr, 32'd0);
    check("refetch_req", {31'd0, bus.req}, 32'd1);
    check("wrap_addr1", bus_w.addr, 32'hFFFF_FFFC);
    push(32'd0);
    tick();
    check("wrap_addr2", bus_w.addr, 32'd0);
    check("wrap_pc_out", w_PC_out, 32'd0);
    check("wrap_instr", w_instruction_out, 32'h5A5A_FFFC);
    check("wrap_valid", {31'd0, w_valid_out}, 32'd1);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
